// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - scanned 4x4 keypad reader building a 4-digit decimal operand
module keypad_entry #(
    parameter int SCAN_DIV = 100000,
    parameter int DB_SCANS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  row_i,
    output logic [0:3]  col_o,
    output logic [13:0] entry_o,
    output logic [2:0]  ndig_o,
    output logic        key_valid_o,
    output logic [3:0]  key_code_o,
    output logic [13:0] value_o,
    output logic        value_valid_o,
    output logic        err_o
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam int CW = $clog2(DB_SCANS + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_SCANS);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD, S_RELEASE} state_t;

    logic [3:0]    row_meta_q, row_sync_q;
    logic [SW-1:0] slot_q;
    logic [1:0]    colidx_q;
    logic [0:3]    col_q;
    logic [15:0]   snap_q;
    logic          scan_done_q;

    state_t        state_q;
    logic [3:0]    cand_q;
    logic [CW-1:0] cnt_q, cnt_inc;
    logic          key_valid_q;
    logic [3:0]    key_code_q;

    logic [13:0]   entry_q, entry_d, value_q, value_d;
    logic [2:0]    ndig_q, ndig_d;
    logic          value_valid_q, value_valid_d, err_q, err_d;

    logic [4:0]    hits;
    logic [3:0]    hit_idx;
    logic          is_none, is_one;

    function automatic logic [0:3] col_drive(input logic [1:0] c);
        logic [0:3] d;
        d    = 4'b1111;
        d[c] = 1'b0;
        return d;
    endfunction

    function automatic logic [3:0] code_of(input logic [3:0] k);
        case (k)
            4'd0:  code_of = 4'd1;
            4'd1:  code_of = 4'd2;
            4'd2:  code_of = 4'd3;
            4'd3:  code_of = 4'd10;
            4'd4:  code_of = 4'd4;
            4'd5:  code_of = 4'd5;
            4'd6:  code_of = 4'd6;
            4'd7:  code_of = 4'd11;
            4'd8:  code_of = 4'd7;
            4'd9:  code_of = 4'd8;
            4'd10: code_of = 4'd9;
            4'd11: code_of = 4'd12;
            4'd12: code_of = 4'd14;
            4'd13: code_of = 4'd0;
            4'd14: code_of = 4'd15;
            default: code_of = 4'd13;
        endcase
    endfunction

    // Snapshot bit index is row*4+col; a set bit means the key was seen pressed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            slot_q      <= '0;
            colidx_q    <= 2'd0;
            col_q       <= 4'b0111;
            snap_q      <= '0;
            scan_done_q <= 1'b0;
        end else begin
            row_meta_q  <= row_i;
            row_sync_q  <= row_meta_q;
            scan_done_q <= 1'b0;
            if (slot_q == SLOT_LAST) begin
                slot_q <= '0;
                for (int r = 0; r < 4; r++) begin
                    snap_q[{2'(r), colidx_q}] <= ~row_sync_q[r];
                end
                colidx_q    <= colidx_q + 2'd1;
                col_q       <= col_drive(colidx_q + 2'd1);
                scan_done_q <= (colidx_q == 2'd3);
            end else begin
                slot_q <= slot_q + 1'b1;
            end
        end
    end

    always_comb begin
        hits    = 5'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_q[i]) begin
                hits    = hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
        is_none = (hits == 5'd0);
        is_one  = (hits == 5'd1);
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_done_q) begin
                case (state_q)
                    S_IDLE: begin
                        if (is_one) begin
                            cand_q <= hit_idx;
                            if (DB_LAST == CW'(1)) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= code_of(hit_idx);
                                state_q     <= S_HELD;
                            end else begin
                                cnt_q   <= CW'(1);
                                state_q <= S_PRESS;
                            end
                        end
                    end
                    S_PRESS: begin
                        if (is_one && hit_idx == cand_q) begin
                            if (cnt_inc == DB_LAST) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= code_of(cand_q);
                                state_q     <= S_HELD;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_HELD: begin
                        if (is_none) begin
                            if (DB_LAST == CW'(1)) begin
                                state_q <= S_IDLE;
                            end else begin
                                cnt_q   <= CW'(1);
                                state_q <= S_RELEASE;
                            end
                        end
                    end
                    default: begin
                        if (is_none) begin
                            if (cnt_inc == DB_LAST) state_q <= S_IDLE;
                            else cnt_q <= cnt_inc;
                        end else begin
                            state_q <= S_HELD;
                        end
                    end
                endcase
            end
        end
    end

    // Four digits cap entry at 9999, so entry*10+d always fits in 14 bits.
    always_comb begin
        entry_d       = entry_q;
        ndig_d        = ndig_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        err_d         = 1'b0;
        if (key_valid_q) begin
            if (key_code_q < 4'd10) begin
                if (ndig_q < 3'd4) begin
                    entry_d = entry_q * 14'd10 + {10'd0, key_code_q};
                    ndig_d  = ndig_q + 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                case (key_code_q)
                    4'd10: begin
                        entry_d = 14'd0;
                        ndig_d  = 3'd0;
                    end
                    4'd11: begin
                        if (ndig_q != 3'd0) begin
                            entry_d = entry_q / 14'd10;
                            ndig_d  = ndig_q - 3'd1;
                        end
                    end
                    4'd15: begin
                        value_d       = entry_q;
                        value_valid_d = 1'b1;
                        entry_d       = 14'd0;
                        ndig_d        = 3'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q       <= 14'd0;
            ndig_q        <= 3'd0;
            value_q       <= 14'd0;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            entry_q       <= entry_d;
            ndig_q        <= ndig_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            err_q         <= err_d;
        end
    end

    assign col_o         = col_q;
    assign entry_o       = entry_q;
    assign ndig_o        = ndig_q;
    assign key_valid_o   = key_valid_q;
    assign key_code_o    = key_code_q;
    assign value_o       = value_q;
    assign value_valid_o = value_valid_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - directed self-checking bench for keypad_entry
`timescale 1ns/1ps
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [0:3]  col;
    logic [13:0] entry;
    logic [2:0]  ndig;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [13:0] value;
    logic        value_valid;
    logic        err;

    logic [15:0] pressed;
    int n_assert = 0;
    int n_fail   = 0;
    int kv_cnt   = 0;
    int vv_cnt   = 0;
    int err_cnt  = 0;
    int exp_e;

    always #5 clk = ~clk;

    keypad_entry #(.SCAN_DIV(4), .DB_SCANS(2)) dut (
        .clk_i(clk), .rst_i(rst), .row_i(row), .col_o(col),
        .entry_o(entry), .ndig_o(ndig), .key_valid_o(key_valid),
        .key_code_o(key_code), .value_o(value), .value_valid_o(value_valid),
        .err_o(err)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid)   kv_cnt  <= kv_cnt + 1;
            if (value_valid) vv_cnt  <= vv_cnt + 1;
            if (err)         err_cnt <= err_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int kidx(input int code);
        case (code)
            1: return 0;   2: return 1;   3: return 2;   10: return 3;
            4: return 4;   5: return 5;   6: return 6;   11: return 7;
            7: return 8;   8: return 9;   9: return 10;  12: return 11;
            14: return 12; 0: return 13;  15: return 14; default: return 15;
        endcase
    endfunction

    task automatic scans(input int n);
        repeat (n * 16) @(posedge clk);
    endtask

    task automatic hit(input int code, input int hold, input int rel);
        pressed = 16'd1 << kidx(code);
        scans(hold);
        pressed = 16'd0;
        scans(rel);
        @(negedge clk);
    endtask

    initial begin
        pressed = 16'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("col_before_reset", 32'(col), 32'b1011);
        #2 rst = 1'b1;
        #1;
        chk("rst_col", 32'(col), 32'b0111);
        chk("rst_entry", 32'(entry), 0);
        chk("rst_ndig", 32'(ndig), 0);
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_key_code", 32'(key_code), 0);
        chk("rst_value", 32'(value), 0);
        chk("rst_value_valid", 32'(value_valid), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("col_hold_slot", 32'(col), 32'b0111);
        @(posedge clk); #1 chk("col_step1", 32'(col), 32'b1011);
        repeat (4) @(posedge clk); #1 chk("col_step2", 32'(col), 32'b1101);
        repeat (4) @(posedge clk); #1 chk("col_step3", 32'(col), 32'b1110);
        repeat (4) @(posedge clk); #1 chk("col_wrap", 32'(col), 32'b0111);

        exp_e = 0;
        for (int i = 1; i <= 4; i++) begin
            hit(i, 3, 3);
            exp_e = exp_e * 10 + i;
            chk("digit_entry", 32'(entry), exp_e);
            chk("digit_key_code", 32'(key_code), i);
        end
        chk("digit_ndig4", 32'(ndig), 4);
        hit(15, 3, 3);
        chk("commit_value", 32'(value), 1234);
        chk("commit_vv_count", 32'(vv_cnt), 1);
        chk("commit_entry_cleared", 32'(entry), 0);
        chk("commit_ndig_cleared", 32'(ndig), 0);
        chk("commit_key_code", 32'(key_code), 15);
        chk("kv_count_5", 32'(kv_cnt), 5);

        repeat (4) hit(9, 3, 3);
        chk("nines_entry", 32'(entry), 9999);
        hit(5, 3, 3);
        chk("overflow_err_count", 32'(err_cnt), 1);
        chk("overflow_entry_kept", 32'(entry), 9999);
        chk("overflow_ndig_kept", 32'(ndig), 4);
        chk("overflow_key_code", 32'(key_code), 5);
        hit(11, 3, 3);
        chk("backspace_entry", 32'(entry), 999);
        chk("backspace_ndig", 32'(ndig), 3);
        hit(10, 3, 3);
        chk("clear_entry", 32'(entry), 0);
        chk("clear_ndig", 32'(ndig), 0);
        hit(11, 3, 3);
        chk("empty_backspace_entry", 32'(entry), 0);
        chk("empty_backspace_ndig", 32'(ndig), 0);
        chk("kv_count_13", 32'(kv_cnt), 13);

        repeat (5) begin
            pressed = 16'd1 << kidx(5); scans(1);
            pressed = 16'd0;            scans(1);
        end
        @(negedge clk) chk("toggle_no_event", 32'(kv_cnt), 13);
        pressed = 16'd1 << kidx(5); scans(2);
        pressed = 16'd0;            scans(3);
        @(negedge clk);
        chk("two_scan_event", 32'(kv_cnt), 14);
        chk("two_scan_entry", 32'(entry), 5);
        pressed = 16'd1 << kidx(5); scans(20);
        @(negedge clk) chk("long_hold_one_event", 32'(kv_cnt), 15);
        repeat (3) begin
            pressed = 16'd0;            scans(1);
            pressed = 16'd1 << kidx(5); scans(1);
        end
        pressed = 16'd0;            scans(1);
        pressed = 16'd1 << kidx(5); scans(3);
        @(negedge clk) chk("bounce_no_event", 32'(kv_cnt), 15);
        pressed = 16'd0;            scans(2);
        pressed = 16'd1 << kidx(5); scans(3);
        pressed = 16'd0;            scans(3);
        @(negedge clk);
        chk("clean_release_event", 32'(kv_cnt), 16);
        chk("clean_release_entry", 32'(entry), 555);

        hit(10, 3, 3);
        pressed = (16'd1 << kidx(1)) | (16'd1 << kidx(2)); scans(3);
        @(negedge clk) chk("multi_no_event", 32'(kv_cnt), 17);
        pressed = 16'd1 << kidx(1); scans(3);
        pressed = 16'd0;            scans(3);
        @(negedge clk);
        chk("multi_release_event", 32'(kv_cnt), 18);
        chk("multi_key_code", 32'(key_code), 1);
        chk("multi_entry", 32'(entry), 1);

        hit(10, 3, 3);
        hit(15, 3, 3);
        chk("empty_commit_value", 32'(value), 0);
        chk("empty_commit_vv_count", 32'(vv_cnt), 2);
        chk("empty_commit_key_code", 32'(key_code), 15);

        hit(7, 3, 3);
        chk("pre_reset_entry", 32'(entry), 7);
        pressed = 16'd1 << kidx(8);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_entry", 32'(entry), 0);
        chk("mid_rst_ndig", 32'(ndig), 0);
        chk("mid_rst_key_code", 32'(key_code), 0);
        chk("mid_rst_col", 32'(col), 32'b0111);
        @(negedge clk) rst = 1'b0;
        scans(3);
        pressed = 16'd0;
        scans(3);
        @(negedge clk);
        chk("post_rst_entry", 32'(entry), 8);
        chk("post_rst_key_code", 32'(key_code), 8);
        chk("kv_count_total", 32'(kv_cnt), 22);
        chk("err_count_total", 32'(err_cnt), 1);
        chk("vv_count_total", 32'(vv_cnt), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
